// File: rtl/pio_in_pkg.sv
// Shared definitions for the pio_in_capture input PIO: register offsets
// within a channel, edge-mode encoding, arm-counter width and the
// per-bit edge detector.
package pio_in_pkg;

    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_EDGE_SEL = 2'd1;
    localparam logic [1:0] REG_IRQ_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE_CAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2,
        EDGE_OFF  = 2'd3
    } edge_mode_e;

    // Wide enough for the longest arming window (SYNC_STAGES max 4, plus 1).
    localparam int ARM_W = 3;

    // Edge vector for one channel; callers zero-extend to 32 bits and
    // slice the result back down to the channel width.
    function automatic logic [31:0] detect_edges(input edge_mode_e mode,
                                                 input logic [31:0] cur,
                                                 input logic [31:0] prev);
        logic [31:0] det;
        case (mode)
            EDGE_RISE: det = cur & ~prev;
            EDGE_FALL: det = ~cur & prev;
            EDGE_ANY:  det = cur ^ prev;
            default:   det = '0;
        endcase
        return det;
    endfunction

endpackage

// File: rtl/pio_in_sync.sv
// Multi-stage synchroniser bank for asynchronous board pins. Every bit gets
// its own STAGES-deep flop chain; all flops clear on reset.
module pio_in_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift the raw inputs through the chain; stage 0 is the metastable one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO with per-channel edge capture and a shared level irq.
// Register map per channel: DATA (RO), EDGE_SEL, IRQ_MASK, EDGE_CAP (W1C).
// Build option: define PIO_IN_SYNC_EN to put a SYNC_STAGES-deep synchroniser
// on every input bit; leave it undefined only for inputs already on clk.
module pio_in_capture
    import pio_in_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [$clog2(N_CH)+1:0]  address,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic [N_CH*DATA_W-1:0]   in_port,
    output logic                     irq
);

    localparam int AW = $clog2(N_CH) + 2;
    localparam int NB = N_CH * DATA_W;
`ifdef PIO_IN_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif
    // Edges are ignored until the synchroniser and prev have flushed the
    // reset-time contents, so start-up transitions never land in EDGE_CAP.
    localparam int ARM_LEN = SYNC_EN ? SYNC_STAGES + 1 : 1;

    logic [NB-1:0]               s_w;
    logic [NB-1:0]               prev_q;
    logic [ARM_W-1:0]            arm_q;
    logic                        armed_w;
    logic [N_CH-1:0][1:0]        sel_q, sel_d;
    logic [N_CH-1:0][DATA_W-1:0] mask_q, mask_d;
    logic [N_CH-1:0][DATA_W-1:0] cap_q, cap_d;
    logic [N_CH-1:0][DATA_W-1:0] det_w;
    logic [31:0]                 readdata_q, readdata_d;
    logic                        irq_q, irq_d;
    logic [AW-1:0]               ch_idx_w;
    logic [1:0]                  reg_w;
    logic                        ch_valid_w;
    logic                        wr_en_w;

`ifdef PIO_IN_SYNC_EN
    pio_in_sync #(
        .WIDTH  (NB),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (s_w)
    );
`else
    assign s_w = in_port;
`endif

    assign reg_w      = address[1:0];
    assign ch_idx_w   = address >> 2;
    assign ch_valid_w = ({{(32-AW){1'b0}}, ch_idx_w} < 32'(N_CH));
    assign wr_en_w    = chipselect & write & ch_valid_w;
    assign armed_w    = (arm_q == ARM_W'(ARM_LEN));

    // Per-channel edge detection according to that channel's EDGE_SEL.
    always_comb begin
        det_w = '0;
        for (int c = 0; c < N_CH; c++) begin
            det_w[c] = DATA_W'(detect_edges(edge_mode_e'(sel_q[c]),
                                            32'(s_w[c*DATA_W +: DATA_W]),
                                            32'(prev_q[c*DATA_W +: DATA_W])));
        end
    end

    // Register writes and capture update; a new edge overrides a W1C clear.
    always_comb begin
        sel_d  = sel_q;
        mask_d = mask_q;
        cap_d  = cap_q;
        for (int c = 0; c < N_CH; c++) begin
            if (wr_en_w && (ch_idx_w == AW'(c))) begin
                case (reg_w)
                    REG_EDGE_SEL: sel_d[c]  = writedata[1:0];
                    REG_IRQ_MASK: mask_d[c] = writedata[DATA_W-1:0];
                    REG_EDGE_CAP: cap_d[c]  = cap_q[c] & ~writedata[DATA_W-1:0];
                    default: ;
                endcase
            end
            if (armed_w) begin
                cap_d[c] = cap_d[c] | det_w[c];
            end
        end
    end

    // Read mux; unmatched channel indices fall through to zero.
    always_comb begin
        readdata_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx_w == AW'(c)) begin
                case (reg_w)
                    REG_DATA:     readdata_d = 32'(s_w[c*DATA_W +: DATA_W]);
                    REG_EDGE_SEL: readdata_d = 32'(sel_q[c]);
                    REG_IRQ_MASK: readdata_d = 32'(mask_q[c]);
                    default:      readdata_d = 32'(cap_q[c]);
                endcase
            end
        end
    end

    assign irq_d = |(cap_q & mask_q);

    // Saturating arm counter, restarted only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q <= '0;
        end else if (!armed_w) begin
            arm_q <= arm_q + 1'b1;
        end
    end

    // Conditioned-input history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= s_w;
        end
    end

    // Configuration and capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q  <= {N_CH{EDGE_OFF}};
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            sel_q  <= sel_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    // Registered bus read data and interrupt output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
